// File: rtl/ctrl_pipe_pkg.sv
// Shared constants for the control-word pipeline: control bit positions,
// default control width and stage indices of the 5-stage core.
package ctrl_pipe_pkg;

   localparam int CTRL_W             = 4;

   localparam int CTRL_REGWRITE      = 0;
   localparam int CTRL_RESULTSRC_LSB = 1;
   localparam int CTRL_RESULTSRC_MSB = 2;
   localparam int CTRL_MEMWRITE      = 3;

   localparam int STG_E = 0;
   localparam int STG_M = 1;
   localparam int STG_W = 2;

endpackage

// File: rtl/ctrl_pipe_stage.sv
// One control pipeline register: WIDTH data bits plus a valid bit, with
// priority reset > flush > hold > bubble > load.
module ctrl_pipe_stage #(
   parameter int               WIDTH  = 4,
   parameter logic [WIDTH-1:0] BUBBLE = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             hold,
   input  logic             bubble,
   input  logic [WIDTH-1:0] d,
   input  logic             vld,
   output logic [WIDTH-1:0] q,
   output logic             vld_q
);

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         q     <= BUBBLE;
         vld_q <= 1'b0;
      end else if (hold) begin
         q     <= q;
         vld_q <= vld_q;
      end else if (bubble) begin
         q     <= BUBBLE;
         vld_q <= 1'b0;
      end else begin
         // An invalid word never carries stale data downstream.
         q     <= vld ? d : BUBBLE;
         vld_q <= vld;
      end
   end

endmodule

// File: rtl/ctrl_pipe_chain.sv
// Parametrised chain of control-word pipeline registers with per-stage stall,
// flush, stall back-propagation and bubble insertion. CTRL_PIPE_PERF_EN adds bubble_cnt_o.
module ctrl_pipe_chain
   import ctrl_pipe_pkg::*;
#(
   parameter int               WIDTH  = CTRL_W,
   parameter int               STAGES = 3,
   parameter logic [WIDTH-1:0] BUBBLE = '0
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [WIDTH-1:0]        d_i,
   input  logic                    valid_i,
   input  logic [STAGES-1:0]       stall_i,
   input  logic [STAGES-1:0]       flush_i,
   output logic [STAGES*WIDTH-1:0] q_o,
   output logic [STAGES-1:0]       valid_o,
   output logic                    hold_i_o
`ifdef CTRL_PIPE_PERF_EN
   ,
   output logic [15:0]             bubble_cnt_o
`endif
);

   logic [WIDTH-1:0]  data_p [STAGES];
   logic [STAGES-1:0] vld_p;
   logic [STAGES-1:0] hold;

   genvar k;
   generate
      for (k = 0; k < STAGES; k++) begin : g_stage
         logic [WIDTH-1:0] up_d;
         logic             up_v;
         logic             bub;

         // A stall anywhere downstream freezes this stage too.
         assign hold[k] = |(stall_i >> k);

         if (k == 0) begin : g_head
            assign up_d = d_i;
            assign up_v = valid_i;
            assign bub  = 1'b0;
         end else begin : g_body
            assign up_d = data_p[k-1];
            assign up_v = vld_p[k-1];
            assign bub  = hold[k-1];
         end

         // ---- stage k register boundary ----
         ctrl_pipe_stage #(
            .WIDTH  (WIDTH),
            .BUBBLE (BUBBLE)
         ) u_stage (
            .clk    (clk),
            .reset  (reset),
            .flush  (flush_i[k]),
            .hold   (hold[k]),
            .bubble (bub),
            .d      (up_d),
            .vld    (up_v),
            .q      (data_p[k]),
            .vld_q  (vld_p[k])
         );

         assign q_o[k*WIDTH +: WIDTH] = data_p[k];
      end
   endgenerate

   assign valid_o  = vld_p;
   assign hold_i_o = hold[0];

`ifdef CTRL_PIPE_PERF_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         bubble_cnt_o <= 16'h0000;
      end else if (!vld_p[STAGES-1] && (bubble_cnt_o != 16'hFFFF)) begin
         bubble_cnt_o <= bubble_cnt_o + 16'h0001;
      end
   end
`endif

endmodule

// File: tb/tb_ctrl_pipe_chain.sv
// Scoreboard bench for ctrl_pipe_chain (WIDTH=4, STAGES=3, BUBBLE=0): a cycle
// model pushes the expected post-edge state, which is popped and compared after each edge.
module tb_ctrl_pipe_chain;

   logic        clk;
   logic        reset;
   logic [3:0]  d_i;
   logic        valid_i;
   logic [2:0]  stall_i;
   logic [2:0]  flush_i;
   logic [11:0] q_o;
   logic [2:0]  valid_o;
   logic        hold_i_o;
`ifdef CTRL_PIPE_PERF_EN
   logic [15:0] bubble_cnt_o;
`endif

   ctrl_pipe_chain #(
      .WIDTH  (4),
      .STAGES (3),
      .BUBBLE (4'h0)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .d_i      (d_i),
      .valid_i  (valid_i),
      .stall_i  (stall_i),
      .flush_i  (flush_i),
      .q_o      (q_o),
      .valid_o  (valid_o),
      .hold_i_o (hold_i_o)
`ifdef CTRL_PIPE_PERF_EN
      ,
      .bubble_cnt_o (bubble_cnt_o)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [11:0] q;
      logic [2:0]  v;
      logic [15:0] cnt;
   } exp_t;

   exp_t sb[$];

   int n_cmp = 0;
   int n_err = 0;

   logic [3:0]  ms [3];
   logic        mv [3];
   logic [15:0] mcnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model; stages updated top-down so each reads its upstream's old value.
   task automatic model_step(input logic [3:0] d, input logic v, input logic [2:0] st,
                             input logic [2:0] fl, input logic rs);
      logic h [3];
      for (int k = 0; k < 3; k++) begin
         h[k] = 1'b0;
         for (int j = k; j < 3; j++) h[k] = h[k] | st[j];
      end
      if (rs) mcnt = 16'h0;
      else if (!mv[2] && mcnt != 16'hFFFF) mcnt = mcnt + 16'h1;
      for (int k = 2; k >= 0; k--) begin
         if (rs || fl[k]) begin
            ms[k] = 4'h0; mv[k] = 1'b0;
         end else if (h[k]) begin
            ms[k] = ms[k]; mv[k] = mv[k];
         end else if (k > 0 && h[k-1]) begin
            ms[k] = 4'h0; mv[k] = 1'b0;
         end else if (k == 0) begin
            ms[0] = v ? d : 4'h0; mv[0] = v;
         end else begin
            ms[k] = ms[k-1]; mv[k] = mv[k-1];
         end
      end
   endtask

   task automatic step(input logic [3:0] d, input logic v, input logic [2:0] st,
                       input logic [2:0] fl, input logic rs);
      exp_t e;
      @(negedge clk);
      d_i = d; valid_i = v; stall_i = st; flush_i = fl; reset = rs;
      #1;
      chk("hold_i_o", {31'd0, hold_i_o}, {31'd0, |st});
      model_step(d, v, st, fl, rs);
      e.q   = {ms[2], ms[1], ms[0]};
      e.v   = {mv[2], mv[1], mv[0]};
      e.cnt = mcnt;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("q_o", {20'd0, q_o}, {20'd0, e.q});
      chk("valid_o", {29'd0, valid_o}, {29'd0, e.v});
`ifdef CTRL_PIPE_PERF_EN
      chk("bubble_cnt", {16'd0, bubble_cnt_o}, {16'd0, e.cnt});
`endif
   endtask

   initial begin
      reset = 1'b1; d_i = 4'h0; valid_i = 1'b0; stall_i = 3'b000; flush_i = 3'b000;
      for (int k = 0; k < 3; k++) begin ms[k] = 4'h0; mv[k] = 1'b0; end
      mcnt = 16'h0;

      step(4'h0, 1'b0, 3'b000, 3'b000, 1'b1);
      step(4'h0, 1'b0, 3'b000, 3'b000, 1'b1);
      chk("reset_q", {20'd0, q_o}, 32'h0);
      chk("reset_v", {29'd0, valid_o}, 32'h0);

      // Fill A, 5, 3
      step(4'hA, 1'b1, 3'b000, 3'b000, 1'b0);
      step(4'h5, 1'b1, 3'b000, 3'b000, 1'b0);
      step(4'h3, 1'b1, 3'b000, 3'b000, 1'b0);
      chk("fill_q", {20'd0, q_o}, 32'hA53);
      chk("fill_v", {29'd0, valid_o}, 32'h7);

      // Stall s1 for two cycles: s0/s1 hold, s2 bubbles
      step(4'h7, 1'b1, 3'b010, 3'b000, 1'b0);
      chk("stall1_q", {20'd0, q_o}, 32'h053);
      chk("stall1_v", {29'd0, valid_o}, 32'h3);
      step(4'h7, 1'b1, 3'b010, 3'b000, 1'b0);
      chk("stall2_q", {20'd0, q_o}, 32'h053);
      step(4'h7, 1'b1, 3'b000, 3'b000, 1'b0);
      chk("resume_q", {20'd0, q_o}, 32'h537);
      chk("resume_v", {29'd0, valid_o}, 32'h7);

      // Flush + stall of s0 together
      step(4'h8, 1'b1, 3'b001, 3'b001, 1'b0);
      chk("fl_st_q", {20'd0, q_o}, 32'h300);
      chk("fl_st_v", {29'd0, valid_o}, 32'h4);
      step(4'h8, 1'b1, 3'b001, 3'b000, 1'b0);
      chk("fl_st_hold_s0", {28'd0, q_o[3:0]}, 32'h0);
      chk("fl_st_hold_v0", {31'd0, valid_o[0]}, 32'h0);

      // Flush s2 while s1 holds 9: 9 is lost
      step(4'h9, 1'b1, 3'b000, 3'b000, 1'b0);
      step(4'h1, 1'b1, 3'b000, 3'b000, 1'b0);
      step(4'h2, 1'b1, 3'b000, 3'b100, 1'b0);
      chk("flush2_q", {20'd0, q_o}, 32'h012);
      chk("flush2_v", {29'd0, valid_o}, 32'h3);

      // valid_i=0 with non-zero data loads BUBBLE
      step(4'hF, 1'b0, 3'b000, 3'b000, 1'b0);
      chk("inval_q", {20'd0, q_o}, 32'h120);
      chk("inval_v", {29'd0, valid_o}, 32'h6);

      // Fill, stall, then reset mid-stall
      step(4'h4, 1'b1, 3'b000, 3'b000, 1'b0);
      step(4'h6, 1'b1, 3'b000, 3'b000, 1'b0);
      step(4'hB, 1'b1, 3'b000, 3'b000, 1'b0);
      step(4'hC, 1'b1, 3'b100, 3'b000, 1'b0);
      step(4'hC, 1'b1, 3'b100, 3'b000, 1'b1);
      chk("rst_stall_q", {20'd0, q_o}, 32'h0);
      chk("rst_stall_v", {29'd0, valid_o}, 32'h0);
`ifdef CTRL_PIPE_PERF_EN
      chk("rst_stall_cnt", {16'd0, bubble_cnt_o}, 32'h0);
`endif

      // Randomised traffic
      for (int i = 0; i < 400; i++) begin
         logic [2:0] st;
         logic [2:0] fl;
         st = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
         fl = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
         step(4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0), st, fl,
              ($urandom_range(0, 49) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, expected finish before 200000");
      $fatal(1);
   end

endmodule
